serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl_pkg.sv | 34 +++
 rtl/serial_add_ctrl_fa_cell.sv | 29 ++
 rtl/serial_add_ctrl.sv | 179 +++++++++++++++++
 tb/tb_serial_add_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// serial_add_pkg
//
// Shared definitions for the bit-serial adder controller.
//
// Contents:
//   ST_IDLE/ST_RUN/ST_DONE : 2-bit state codes. They are kept as plain
//                            constants so older code that compares raw
//                            state bits keeps working.
//   state_t                : typed state enum built on those codes.
//   cnt_width()            : width of the bit-position counter for a given
//                            operand width.
//
// Optional build macro used by the controller: SERIAL_ADD_OVF_EN.
// ---------------------------------------------------------------------------
package serial_add_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN,
      DONE = ST_DONE
   } state_t;

   // One extra bit over $clog2 so that WIDTH-1 is always representable,
   // including the WIDTH=1 case where $clog2 returns 0.
   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage : serial_add_pkg

// File: rtl/serial_add_ctrl_fa_cell.sv
// ---------------------------------------------------------------------------
// fa_cell
//
// Purely combinational 1-bit full adder. It is the only arithmetic element
// of the serial adder; the controller feeds it one bit position per clock.
//
// Ports:
//   a, b  : operand bits
//   ci    : carry in
//   s     : sum bit
//   co    : carry out
// ---------------------------------------------------------------------------
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   logic ab_xor;

   assign ab_xor = a ^ b;
   assign s      = ab_xor ^ ci;
   // Generate when both operand bits are set, propagate the incoming carry
   // when exactly one is set.
   assign co     = (a & b) | (ab_xor & ci);

endmodule : fa_cell

// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial adder controller. One fa_cell is time-shared across every bit
// position of two WIDTH-bit operands, LSB first, one bit per clock. The
// result is registered and presented with a valid/ready handshake.
//
// Parameters:
//   WIDTH      : operand/result width in bits, 1..64
//
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous reset, active-high, overrides all handshakes
//   in_valid   : operand set offered
//   in_ready   : operands can be accepted (high only while idle)
//   a_in, b_in : operands, sampled only on the accepting edge
//   cin        : carry into bit 0, sampled with the operands
//   out_valid  : result available (high only while done)
//   out_ready  : consumer takes the result
//   sum        : registered WIDTH-bit sum (modulo 2^WIDTH)
//   cout       : registered carry out of the MSB
//   ovf        : registered signed overflow flag; present only when the
//                macro SERIAL_ADD_OVF_EN is defined
//
// Timing: out_valid rises exactly WIDTH clocks after the accepting edge.
// Minimum spacing between operations is WIDTH+2 clocks.
// ---------------------------------------------------------------------------
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = cnt_width(WIDTH);

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   state_t           state_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] acc_reg;
   logic [WIDTH-1:0] sum_reg;
   logic             carry_reg;
   logic             cout_reg;
   logic [CW-1:0]    cnt_reg;
`ifdef SERIAL_ADD_OVF_EN
   logic             ovf_reg;
`endif

   // ------------------------------------------------------------------
   // Combinational next values for the shifting datapath
   // ------------------------------------------------------------------
   logic             fa_s;
   logic             fa_co;
   logic [WIDTH-1:0] a_next;
   logic [WIDTH-1:0] b_next;
   logic [WIDTH-1:0] acc_next;
   logic             last_bit;
   logic             accept;
   logic             consume;

   fa_cell u_fa_cell (
      .a  (a_reg[0]),
      .b  (b_reg[0]),
      .ci (carry_reg),
      .s  (fa_s),
      .co (fa_co)
   );

   // Right shifts written bit by bit so that WIDTH=1 needs no special
   // slice: the loop is simply empty and only the MSB assignment remains.
   // The accumulator takes the fresh sum bit in at the top; after WIDTH
   // shifts bit 0 of the result has reached position 0.
   assign a_next[WIDTH-1]   = 1'b0;
   assign b_next[WIDTH-1]   = 1'b0;
   assign acc_next[WIDTH-1] = fa_s;

   generate
      for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
         assign a_next[gi]   = a_reg[gi + 1];
         assign b_next[gi]   = b_reg[gi + 1];
         assign acc_next[gi] = acc_reg[gi + 1];
      end
   endgenerate

   assign last_bit = (cnt_reg == CW'(WIDTH - 1));
   assign accept   = in_valid  && (state_reg == IDLE);
   assign consume  = out_ready && (state_reg == DONE);

   // ------------------------------------------------------------------
   // Sequencing
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         acc_reg   <= '0;
         sum_reg   <= '0;
         carry_reg <= 1'b0;
         cout_reg  <= 1'b0;
         cnt_reg   <= '0;
`ifdef SERIAL_ADD_OVF_EN
         ovf_reg   <= 1'b0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  a_reg     <= a_in;
                  b_reg     <= b_in;
                  carry_reg <= cin;
                  cnt_reg   <= '0;
                  state_reg <= RUN;
               end
            end

            RUN: begin
               a_reg     <= a_next;
               b_reg     <= b_next;
               acc_reg   <= acc_next;
               carry_reg <= fa_co;
               cnt_reg   <= cnt_reg + CW'(1);
               if (last_bit) begin
                  // The MSB is being added this cycle: publish the full
                  // result straight from the shift path so it is not one
                  // clock late.
                  sum_reg   <= acc_next;
                  cout_reg  <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
                  // carry_reg still holds the carry into the MSB here.
                  ovf_reg   <= carry_reg ^ fa_co;
`endif
                  state_reg <= DONE;
               end
            end

            DONE: begin
               if (consume) begin
                  state_reg <= IDLE;
               end
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign in_ready  = (state_reg == IDLE);
   assign out_valid = (state_reg == DONE);
   assign sum       = sum_reg;
   assign cout      = cout_reg;
`ifdef SERIAL_ADD_OVF_EN
   assign ovf       = ovf_reg;
`endif

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_add_ctrl
//
// Self-checking bench for serial_add_ctrl (WIDTH=8). A timeline model
// predicts handshake levels and the registered result from plain integer
// arithmetic; a compare process checks every output on every falling edge.
// Directed operations pin the model with hand-computed literals, then a
// randomized run exercises backpressure and ignored input offers.
// ---------------------------------------------------------------------------
module tb_serial_add_ctrl;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a_in = '0;
   logic [WIDTH-1:0] b_in = '0;
   logic             cin = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef SERIAL_ADD_OVF_EN
   logic             ovf;
`endif

   serial_add_ctrl #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_in      (a_in),
      .b_in      (b_in),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
`ifdef SERIAL_ADD_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Signed overflow from the integer value of the signed sum.
   function automatic bit ovf_of(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
      int sa;
      int sb;
      int s;
      sa = $signed(a);
      sb = $signed(b);
      s  = sa + sb + int'(c);
      return (s > 127) || (s < -128);
   endfunction

   // ------------------------------------------------------------------
   // Behavioural model: phase 0 = waiting for operands, 1 = busy for
   // WIDTH clocks, 2 = result offered.
   // ------------------------------------------------------------------
   int               m_phase = 0;
   int               m_cnt   = 0;
   logic [WIDTH:0]   m_res   = '0;
   bit               m_ovf_p = 1'b0;
   logic [WIDTH-1:0] m_sum   = '0;
   logic             m_cout  = 1'b0;
   bit               m_ovf   = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_phase <= 0;
         m_cnt   <= 0;
         m_sum   <= '0;
         m_cout  <= 1'b0;
         m_ovf   <= 1'b0;
      end else if (m_phase == 0) begin
         if (in_valid) begin
            m_phase <= 1;
            m_cnt   <= WIDTH;
            m_res   <= (WIDTH+1)'(a_in) + (WIDTH+1)'(b_in) + (WIDTH+1)'(cin);
            m_ovf_p <= ovf_of(a_in, b_in, cin);
         end
      end else if (m_phase == 1) begin
         if (m_cnt == 1) begin
            m_phase <= 2;
            m_sum   <= m_res[WIDTH-1:0];
            m_cout  <= m_res[WIDTH];
            m_ovf   <= m_ovf_p;
         end else begin
            m_cnt <= m_cnt - 1;
         end
      end else begin
         if (out_ready) m_phase <= 0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready",  in_ready,  m_phase == 0);
         chk("out_valid", out_valid, m_phase == 2);
         chk("sum",       sum,       m_sum);
         chk("cout",      cout,      m_cout);
`ifdef SERIAL_ADD_OVF_EN
         chk("ovf",       ovf,       m_ovf);
`endif
      end
   end

   // ------------------------------------------------------------------
   // One operation: offer, accept, wait for result, optional backpressure
   // with ignored in_valid pulses, consume.
   // ------------------------------------------------------------------
   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input int hold, input bit noise,
                        output logic [7:0] s, output logic co, output int lat);
      int guard;
      logic [7:0] s0;
      logic       c0;
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      chk("wait_in_ready", guard < 50, 1);
      in_valid = 1'b1;
      a_in = a;
      b_in = b;
      cin  = c;
      @(posedge clk); #1;
      // Accepted on that edge; later changes must have no effect.
      if (noise) begin
         a_in = 8'h11;
         b_in = 8'h22;
      end else begin
         in_valid = 1'b0;
         a_in = 8'($urandom);
         b_in = 8'($urandom);
      end
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("wait_out_valid", lat < 100, 1);
      in_valid = 1'b0;
      s0 = sum;
      c0 = cout;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'($urandom);
         a_in = 8'($urandom);
         b_in = 8'($urandom);
         @(posedge clk); #1;
         chk("bp_valid", out_valid, 1);
         chk("bp_sum",   sum,  s0);
         chk("bp_cout",  cout, c0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      s  = sum;
      co = cout;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("post_in_ready",  in_ready,  1);
      chk("post_out_valid", out_valid, 0);
      $display("txn a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d lat=%0d hold=%0d",
               a, b, c, s, co, lat, hold);
   endtask

   initial begin
      logic [7:0] s;
      logic       co;
      int         lat;

      // Reset
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk_en = 1'b1;
      chk("rst_in_ready",  in_ready,  1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum",       sum,       0);
      chk("rst_cout",      cout,      0);

      // Basic add with latency
      do_op(8'h35, 8'h4A, 1'b0, 0, 1'b0, s, co, lat);
      chk("t1_sum", s, 8'h7F);
      chk("t1_cout", co, 0);
      chk("t1_latency", lat, 8);

      do_op(8'hFF, 8'h01, 1'b0, 0, 1'b0, s, co, lat);
      chk("t2_sum", s, 8'h00);
      chk("t2_cout", co, 1);

      do_op(8'h00, 8'h00, 1'b1, 0, 1'b0, s, co, lat);
      chk("t3_sum", s, 8'h01);
      chk("t3_cout", co, 0);

`ifdef SERIAL_ADD_OVF_EN
      do_op(8'h7F, 8'h01, 1'b0, 0, 1'b0, s, co, lat);
      chk("ovf1_sum", s, 8'h80);
      chk("ovf1_flag", ovf, 1);
      chk("ovf1_cout", co, 0);
      do_op(8'hFF, 8'h01, 1'b0, 0, 1'b0, s, co, lat);
      chk("ovf2_flag", ovf, 0);
      chk("ovf2_cout", co, 1);
`endif

      // Backpressure for 5 cycles
      do_op(8'h12, 8'h34, 1'b0, 5, 1'b0, s, co, lat);
      chk("bp_result", s, 8'h46);

      // in_valid held high with other operands during RUN
      do_op(8'h35, 8'h4A, 1'b0, 0, 1'b1, s, co, lat);
      chk("inflight_sum", s, 8'h7F);
      do_op(8'h11, 8'h22, 1'b0, 0, 1'b0, s, co, lat);
      chk("inflight_next", s, 8'h33);

      // Reset in the third RUN cycle
      in_valid = 1'b1;
      a_in = 8'h35;
      b_in = 8'h4A;
      cin  = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_sum",       sum,       0);
      chk("mid_rst_cout",      cout,      0);
      chk("mid_rst_in_ready",  in_ready,  1);
      do_op(8'h35, 8'h4A, 1'b0, 0, 1'b0, s, co, lat);
      chk("after_rst_sum", s, 8'h7F);
      chk("after_rst_lat", lat, 8);

      // Randomized operations
      for (int i = 0; i < 40; i++) begin
         logic [7:0] ra;
         logic [7:0] rb;
         logic       rc;
         logic [8:0] ref_v;
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 1'($urandom);
         ref_v = 9'(ra) + 9'(rb) + 9'(rc);
         do_op(ra, rb, rc, int'($urandom_range(0, 3)), 1'($urandom), s, co, lat);
         chk("rnd_sum",  s,   ref_v[7:0]);
         chk("rnd_cout", co,  ref_v[8]);
         chk("rnd_lat",  lat, 8);
      end

      repeat (2) @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_serial_add_ctrl
